// File: rtl/adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq
// Purpose  : Multi-cycle W-bit adder/subtractor built on one 4-bit slice,
//            processing one nibble per clock LSB first with a registered carry.
//            Optional macro ADDER_SEQ_ABORT_EN adds an i_abort input.
// Revision : 1.0 - initial release
// ============================================================================
module adder_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic                   i_sub,
   input  logic [4*NIBBLES-1:0]   i_a,
   input  logic [4*NIBBLES-1:0]   i_b,
   input  logic                   i_c,
`ifdef ADDER_SEQ_ABORT_EN
   input  logic                   i_abort,
`endif
   output logic                   o_busy,
   output logic                   o_done,
   output logic [4*NIBBLES-1:0]   o_sum,
   output logic                   o_carry,
   output logic                   o_over
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] C_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_work;
   logic [W-1:0]    w_work_next;
   logic [KW-1:0]   r_k;
   logic            r_cr;
   logic [KW+1:0]   w_idx;
   logic [3:0]      w_na;
   logic [3:0]      w_nb;
   logic [4:0]      w_nsum;
   logic            w_abort;
   logic            w_start_acc;
   logic            w_run;
   logic            w_last;

`ifdef ADDER_SEQ_ABORT_EN
   assign w_abort = i_abort;
`else
   assign w_abort = 1'b0;
`endif

   // A start is honoured in IDLE and in the DONE cycle, never while running.
   assign w_start_acc = i_start && (r_state != S_RUN);
   assign w_run       = (r_state == S_RUN) && !w_abort;
   assign w_last      = w_run && (r_k == C_LAST);
   assign w_idx       = {r_k, 2'b00};

   always_comb begin
      w_na        = r_a[w_idx +: 4];
      w_nb        = r_b[w_idx +: 4];
      w_nsum      = {1'b0, w_na} + {1'b0, w_nb} + {4'b0000, r_cr};
      w_work_next = r_work;
      w_work_next[w_idx +: 4] = w_nsum[3:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_acc) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_abort)     w_state_next = S_IDLE;
            else if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_state_next = w_start_acc ? S_RUN : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Subtraction is folded into the operand latch: A + ~B + ~borrow.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_k     <= '0;
         r_cr    <= 1'b0;
         o_sum   <= '0;
         o_carry <= 1'b0;
         o_over  <= 1'b0;
      end else if (w_start_acc) begin
         r_a  <= i_a;
         r_b  <= i_sub ? ~i_b : i_b;
         r_cr <= i_sub ? ~i_c : i_c;
         r_k  <= '0;
      end else if (w_run) begin
         r_work <= w_work_next;
         r_cr   <= w_nsum[4];
         if (w_last) begin
            o_sum   <= w_work_next;
            o_carry <= w_nsum[4];
            o_over  <= w_nsum[3] ^ r_a[W-1] ^ r_b[W-1] ^ w_nsum[4];
         end else begin
            r_k <= r_k + 1'b1;
         end
      end
   end

   assign o_busy = (r_state == S_RUN);
   assign o_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adder_seq.sv
`default_nettype none
// Self-checking bench for adder_seq (NIBBLES=4) using directed vectors.
module tb_adder_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sub;
   logic [15:0] a;
   logic [15:0] b;
   logic        c;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        carry;
   logic        over;
`ifdef ADDER_SEQ_ABORT_EN
   logic        abort;
`endif

   int total = 0;
   int bad   = 0;

   adder_seq #(.NIBBLES(4)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_sub   (sub),
      .i_a     (a),
      .i_b     (b),
      .i_c     (c),
`ifdef ADDER_SEQ_ABORT_EN
      .i_abort (abort),
`endif
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_carry (carry),
      .o_over  (over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operation from the current cycle and follows it until o_done.
   // dcyc is the cycle (relative to the start edge) in which o_done is seen.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic ts, input logic tc, input bit pulse,
                        output int dcyc, output int bcnt, output bit ovl);
      a = ta; b = tbv; sub = ts; c = tc; start = 1'b1;
      dcyc = -1; bcnt = 0; ovl = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~ts; c = ~tc;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (busy && done) ovl = 1'b1;
         if (done) begin
            dcyc = cyc;
            break;
         end
         if (busy) bcnt++;
         start = pulse && (cyc == 2 || cyc == 3);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, sum, carry, over} !== 20'h0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h carry=%b over=%b want all 0",
                  busy, done, sum, carry, over);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic check_op(input string nm, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic ts, input logic tc, input logic [15:0] es,
                           input logic ec, input logic eo);
      int  dcyc, bcnt;
      bit  ovl;
      do_op(ta, tbv, ts, tc, 1'b0, dcyc, bcnt, ovl);
      total++;
      if (dcyc !== 5 || bcnt !== 4 || ovl !== 1'b0) begin
         bad++;
         $display("FAIL %s_timing got done_cycle=%0d busy_cycles=%0d overlap=%0d want 5 4 0",
                  nm, dcyc, bcnt, ovl);
      end
      total++;
      if ({sum, carry, over} !== {es, ec, eo}) begin
         bad++;
         $display("FAIL %s_result got sum=%h carry=%b over=%b want sum=%h carry=%b over=%b",
                  nm, sum, carry, over, es, ec, eo);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_pulse got done=%b busy=%b after DONE want 0 0", nm, done, busy);
      end
   endtask

   task automatic test_add();
      check_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
      check_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      check_op("add_cin",   16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0);
   endtask

   task automatic test_sub();
      check_op("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      check_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      check_op("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int dcyc, bcnt;
      bit ovl;
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, dcyc, bcnt, ovl);
      total++;
      if (dcyc !== 5 || sum !== 16'h0000 || carry !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first got done_cycle=%0d sum=%h carry=%b want 5 0000 1",
                  dcyc, sum, carry);
      end
      // Second start issued in the DONE cycle of the first.
      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, dcyc, bcnt, ovl);
      total++;
      if (dcyc !== 5 || bcnt !== 4 || ovl !== 1'b0) begin
         bad++;
         $display("FAIL b2b_timing got done_gap=%0d busy_cycles=%0d overlap=%0d want 5 4 0",
                  dcyc, bcnt, ovl);
      end
      total++;
      if ({sum, carry, over} !== {16'h2233, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL b2b_result got sum=%h carry=%b over=%b want 2233 0 0", sum, carry, over);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_during_run();
      int dcyc, bcnt;
      bit ovl;
      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, dcyc, bcnt, ovl);
      total++;
      if (dcyc !== 5 || bcnt !== 4 || ovl !== 1'b0) begin
         bad++;
         $display("FAIL run_start_timing got done_cycle=%0d busy_cycles=%0d overlap=%0d want 5 4 0",
                  dcyc, bcnt, ovl);
      end
      total++;
      if ({sum, carry, over} !== {16'h2233, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL run_start_result got sum=%h carry=%b over=%b want 2233 0 0",
                  sum, carry, over);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int  dcyc, bcnt;
      bit  ovl;
      bit  seen_done;
      a = 16'hFFFF; b = 16'h0001; sub = 1'b0; c = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({busy, done, sum, carry, over} !== 20'h0) begin
         bad++;
         $display("FAIL rst_mid_run got busy=%b done=%b sum=%h carry=%b over=%b want all 0",
                  busy, done, sum, carry, over);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen_done !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_run_quiet got activity=1 want 0");
      end
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, dcyc, bcnt, ovl);
      total++;
      if (dcyc !== 5 || {sum, carry, over} !== {16'h8000, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rst_recover got done_cycle=%0d sum=%h carry=%b over=%b want 5 8000 0 1",
                  dcyc, sum, carry, over);
      end
      @(posedge clk); #1;
   endtask

`ifdef ADDER_SEQ_ABORT_EN
   task automatic test_abort();
      int dcyc, bcnt;
      bit ovl;
      bit seen;
      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, dcyc, bcnt, ovl);
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'h0001; sub = 1'b0; c = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done) seen = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 1'b0 || {sum, carry, over} !== {16'h2233, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL abort_hold got done_seen=%b sum=%h carry=%b over=%b want 0 2233 0 0",
                  seen, sum, carry, over);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c = 1'b0;
`ifdef ADDER_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_start_during_run();
      test_reset_mid_run();
`ifdef ADDER_SEQ_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
